// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: sequencer state encoding plus opcode and
// func_code enumerations used by the sequencer and control_signal_simplified.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        FETCH_INSTR   = 3'b000,
        DECODE        = 3'b001,
        EXECUTE       = 3'b010,
        MEMORY_ACCESS = 3'b011,
        WRITE_BACK    = 3'b100,
        HALT          = 3'b101
    } state_t;

    localparam logic [2:0] HALT_CODE = 3'b101;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'b000000,
        OP_REGIMM  = 6'b000001,
        OP_J       = 6'b000010,
        OP_JAL     = 6'b000011,
        OP_BEQ     = 6'b000100,
        OP_BNE     = 6'b000101,
        OP_BLEZ    = 6'b000110,
        OP_BGTZ    = 6'b000111,
        OP_ADDI    = 6'b001000,
        OP_ADDIU   = 6'b001001,
        OP_SLTI    = 6'b001010,
        OP_SLTIU   = 6'b001011,
        OP_ANDI    = 6'b001100,
        OP_ORI     = 6'b001101,
        OP_XORI    = 6'b001110,
        OP_LUI     = 6'b001111,
        OP_LB      = 6'b100000,
        OP_LH      = 6'b100001,
        OP_LWL     = 6'b100010,
        OP_LW      = 6'b100011,
        OP_LBU     = 6'b100100,
        OP_LHU     = 6'b100101,
        OP_LWR     = 6'b100110,
        OP_SB      = 6'b101000,
        OP_SH      = 6'b101001,
        OP_SWL     = 6'b101010,
        OP_SW      = 6'b101011
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL   = 6'b000000,
        FN_SRL   = 6'b000010,
        FN_SRA   = 6'b000011,
        FN_SLLV  = 6'b000100,
        FN_SRLV  = 6'b000110,
        FN_SRAV  = 6'b000111,
        FN_JR    = 6'b001000,
        FN_JALR  = 6'b001001,
        FN_MFHI  = 6'b010000,
        FN_MTHI  = 6'b010001,
        FN_MFLO  = 6'b010010,
        FN_MTLO  = 6'b010011,
        FN_MULT  = 6'b011000,
        FN_MULTU = 6'b011001,
        FN_DIV   = 6'b011010,
        FN_DIVU  = 6'b011011,
        FN_ADD   = 6'b100000,
        FN_ADDU  = 6'b100001,
        FN_SUB   = 6'b100010,
        FN_SUBU  = 6'b100011,
        FN_AND   = 6'b100100,
        FN_OR    = 6'b100101,
        FN_XOR   = 6'b100110,
        FN_NOR   = 6'b100111,
        FN_SLT   = 6'b101010,
        FN_SLTU  = 6'b101011
    } func_t;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction classifier: tells the sequencer whether the
// instruction touches memory, uses the mult/div unit, or finishes in EXECUTE.
module mips_cpu_instr_class
    import mips_cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func_code,
    output logic       is_load,
    output logic       is_store,
    output logic       is_multdiv,
    output logic       ends_in_execute
);

    always_comb begin
        is_load         = (opcode >= OP_LB) && (opcode <= OP_LWR);
        is_store        = (opcode >= OP_SB) && (opcode <= OP_SW);
        is_multdiv      = 1'b0;
        ends_in_execute = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (func_code)
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        is_multdiv      = 1'b1;
                        ends_in_execute = 1'b1;
                    end
                    FN_JR, FN_MTHI, FN_MTLO:
                        ends_in_execute = 1'b1;
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_JALR, FN_MFHI, FN_MFLO,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                        ends_in_execute = 1'b0;
                    // Unknown R-type function behaves as a NOP.
                    default:
                        ends_in_execute = 1'b1;
                endcase
            end
            OP_REGIMM, OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                ends_in_execute = 1'b1;
            OP_JAL, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                ends_in_execute = 1'b0;
            default:
                ends_in_execute = !(is_load || is_store);
        endcase
    end

endmodule

// File: rtl/mips_cpu_state_sequencer.sv
// Multi-cycle MIPS instruction sequencer: walks FETCH/DECODE/EXECUTE/MEMORY/
// WRITE_BACK, honours memory and mult/div stalls, halts when PC reaches zero.
module mips_cpu_state_sequencer
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic        waitrequest,
    input  logic        alu_busy,
    input  logic        pc_is_zero,
    output logic [2:0]  state,
    output logic        active,
    output logic        instr_done,
    output logic [31:0] cycle_count
);

    state_t      state_q;
    logic        active_q;
    logic [31:0] cycle_count_q;

    logic is_load;
    logic is_store;
    logic is_multdiv;
    logic ends_in_execute;
    logic end_instr;

    mips_cpu_instr_class u_class (
        .opcode          (opcode),
        .func_code       (func_code),
        .is_load         (is_load),
        .is_store        (is_store),
        .is_multdiv      (is_multdiv),
        .ends_in_execute (ends_in_execute)
    );

    // The last cycle of a stalled instruction is only known once the stall
    // drops, so the end flag is the registered state qualified by the stall.
    always_comb begin
        end_instr = 1'b0;
        case (state_q)
            EXECUTE:       end_instr = is_multdiv ? !alu_busy : ends_in_execute;
            MEMORY_ACCESS: end_instr = is_store ? !waitrequest : !is_load;
            WRITE_BACK:    end_instr = 1'b1;
            default:       end_instr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH_INSTR;
            active_q      <= 1'b1;
            cycle_count_q <= 32'd0;
        end else begin
            if (active_q)
                cycle_count_q <= cycle_count_q + 32'd1;
            if (end_instr) begin
                state_q <= pc_is_zero ? HALT : FETCH_INSTR;
                if (pc_is_zero)
                    active_q <= 1'b0;
            end else begin
                case (state_q)
                    FETCH_INSTR:   if (!waitrequest) state_q <= DECODE;
                    DECODE:        state_q <= EXECUTE;
                    EXECUTE:       if (!is_multdiv) state_q <= MEMORY_ACCESS;
                    MEMORY_ACCESS: if (is_load && !waitrequest) state_q <= WRITE_BACK;
                    HALT:          state_q <= HALT;
                    default:       state_q <= FETCH_INSTR;
                endcase
            end
        end
    end

    assign state       = state_q;
    assign active      = active_q;
    assign cycle_count = cycle_count_q;
    // A reset edge aborts the instruction, so no completion is reported.
    assign instr_done  = end_instr && reset;

endmodule
